// File: rtl/result_bcd_converter.sv
// Bit-serial binary-to-BCD (double-dabble) converter behind the ALU: one bit per clock, done W+1 edges after start.
// Starts arriving while busy are dropped, not queued; abort cancels a conversion without touching bcd/ndigits.
module result_bcd_converter #(
  parameter int inSize = 4,
  parameter int DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [2*inSize-1:0]             value,
  output logic                            busy,
  output logic                            done,
  output logic [4*DIGITS-1:0]             bcd,
  output logic [$clog2(DIGITS+1)-1:0]     ndigits
);

  localparam int W  = 2*inSize;
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(W+1);
  localparam int NW = $clog2(DIGITS+1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // The digit field must hold the largest W-bit value.
  if (pow10(DIGITS) <= (longint'(1) << W) - 1) begin : g_digits_chk
    $error("result_bcd_converter: DIGITS too small for 2*inSize-bit input");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_n;
  logic [W-1:0]    bin, bin_n;
  logic [BW-1:0]   scratch, scratch_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bcd_n;
  logic [NW-1:0]   ndigits_n;
  logic            done_n;

  logic [BW-1:0]   adjusted;
  logic [BW+W-1:0] shifted;
  logic [NW-1:0]   nd_calc;

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted, bin} << 1;
    nd_calc = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[W + 4*i +: 4] != 4'd0) nd_calc = NW'(i + 1);
    end
  end

  always_comb begin
    state_n   = state;
    bin_n     = bin;
    scratch_n = scratch;
    cnt_n     = cnt;
    bcd_n     = bcd;
    ndigits_n = ndigits;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          bin_n     = value;
          scratch_n = '0;
          cnt_n     = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          scratch_n = shifted[BW+W-1:W];
          bin_n     = shifted[W-1:0];
          cnt_n     = cnt + CW'(1);
          // Final iteration publishes the freshly shifted scratch, not the stale register.
          if (cnt == CW'(W-1)) begin
            bcd_n     = shifted[BW+W-1:W];
            ndigits_n = nd_calc;
            done_n    = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin     <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      ndigits <= NW'(1);
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      bin     <= bin_n;
      scratch <= scratch_n;
      cnt     <= cnt_n;
      bcd     <= bcd_n;
      ndigits <= ndigits_n;
      done    <= done_n;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the calculator ALU.
- Captures the 2*inSize-bit unsigned ALU result when the ALU signals valid.
- Converts the value with the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Presents packed BCD digits and a significant-digit count to the display driver.

Parameters:
- inSize, 4: ALU operand width; input result width is W = 2*inSize.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^W - 1; an elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  ALU valid; value is sampled on a rising edge in IDLE.
- abort  input  1  synchronous cancel of a conversion in progress.
- value  input  2*inSize  unsigned ALU result.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/ndigits are updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- ndigits  output  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, bcd=0, ndigits=1; internal shift register and counter cleared. Reset low mid-conversion discards the conversion; no done pulse follows.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1, load value into the binary shift register, clear the BCD scratch register and counter, and go to SHIFT.
  - busy rises after this edge.
- SHIFT, each edge, one iteration:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, binary} shifts left one bit.
  - Counter increments.
- On the edge completing iteration W:
  - bcd <= final scratch, ndigits <= computed count, done <= 1 for exactly one cycle.
  - State returns to IDLE; busy falls after the same edge.
- Latency: start sampled at edge k; done high during the cycle after edge k+W. busy is high during the cycles after edges k..k+W-1.
- start while busy: ignored; no queueing.
- start high during the done cycle: accepted, since the state is already IDLE. Back-to-back throughput is one result per W+1 cycles.
- abort=1 in SHIFT:
  - Return to IDLE on that edge.
  - bcd/ndigits keep their previous values; no done pulse.
  - abort takes priority over completion on the final iteration.
  - abort in IDLE has no effect and does not block a simultaneous start.
- ndigits: index of the most significant nonzero digit + 1. A value of 0 gives ndigits=1.
- bcd and ndigits are registered and change only on the done edge, so they are stable between conversions.
- value is unsigned. Subtraction results that wrap in the ALU are converted as the raw unsigned bit pattern.

Test Plan (inSize=4, W=8, DIGITS=3):
- Reset, then start with value=0 → done 9 cycles after the start edge; bcd=12'h000, ndigits=1.
- value=255 → bcd=12'h255, ndigits=3; busy high for exactly 8 cycles; done high for exactly 1 cycle.
- value=100, then start asserted during the done cycle with value=9 → first done bcd=12'h100, ndigits=3; second done 9 cycles later with bcd=12'h009, ndigits=1.
- value=47 converting; pulse start with value=200 at iteration 3 → second start ignored; done gives bcd=12'h047, ndigits=2; no further done.
- value=63 converting; abort at iteration 5 → busy drops next cycle, no done; bcd keeps the previous result; a new start with 63 later gives 12'h063, ndigits=2.
- rst driven low asynchronously mid-conversion (between clock edges) → outputs zero immediately (bcd=0, ndigits=1, busy=0); after release, no done until a new start.
